// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
//
// Memory-side responder for the core's load/store port. One word-aligned
// read or write is accepted at a time over a valid/ready handshake. After a
// fixed number of cycles the access is performed and a response is returned
// over a second valid/ready handshake. Misaligned and out-of-range accesses
// are flagged with rsp_err instead of being aliased onto real storage.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit storage words (byte range 0 .. 4*DEPTH-1)
//   LATENCY      cycles from request acceptance to response valid (1..15)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears state and storage
//   req_valid  request present
//   req_ready  responder can accept a request (only in IDLE, out of reset)
//   req_we     1 = write, 0 = read
//   req_addr   byte address
//   req_wdata  write data
//   req_be     byte enables for writes, bit i covers bits [8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  read data; 0 for writes and errored accesses
//   rsp_err    access was misaligned or out of range
// ---------------------------------------------------------------------------
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic [3:0]         count;

    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;

    // The data array itself has no reset. A per-word "written since reset"
    // bit stands in for clearing every word: a word whose bit is clear reads
    // as zero, which is exactly what a cleared word would hold.
    logic [31:0]            mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] word_valid;

    logic               misaligned;
    logic               in_range;
    logic               access_err;
    logic [AW-1:0]      safe_idx;
    logic [31:0]        cur_word;
    logic [31:0]        merged_word;
    logic               access_now;
    logic               do_write;

    // Address decode of the latched request. The index is forced to 0 when
    // the word is outside storage so the array is never read out of bounds;
    // such accesses are errors and never use the data.
    always_comb begin
        misaligned = (lat_addr[1:0] != 2'b00);
        in_range   = ({2'b00, lat_addr[31:2]} < 32'(DEPTH_WORDS));
        access_err = misaligned || !in_range;
        safe_idx   = in_range ? lat_addr[AW+1:2] : '0;
        cur_word   = word_valid[safe_idx] ? mem[safe_idx] : 32'h0;
    end

    // Byte-merge for writes: enabled bytes come from the request, the rest
    // keep the current word contents.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (lat_be[b]) begin
                merged_word[8*b +: 8] = lat_wdata[8*b +: 8];
            end
        end
    end

    assign access_now = (state == ST_WAIT) && (count == 4'd0);
    assign do_write   = access_now && lat_we && !access_err;

    // Ready is gated by reset so it is low while reset is held, yet high in
    // the very first cycle after release without waiting for a clock edge.
    assign req_ready = reset && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    // Transaction FSM: latches the request in IDLE, counts down in WAIT,
    // performs the access on the WAIT->RESP edge and holds the response
    // registers stable in RESP until the requester takes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            count      <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_be     <= 4'h0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            word_valid <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        count     <= 4'(LATENCY - 1);
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count == 4'd0) begin
                        if (access_err) begin
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b1;
                        end else if (lat_we) begin
                            word_valid[safe_idx] <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b0;
                        end else begin
                            rsp_rdata <= cur_word;
                            rsp_err   <= 1'b0;
                        end
                        state <= ST_RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage write port. Reset forces the FSM to IDLE asynchronously, so no
    // write can land while reset is low or for an aborted transaction.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[safe_idx] <= merged_word;
        end
    end

endmodule
